// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: privilege encoding, the stored
// trace entry layout and a few fixed widths.
package commit_trace_buffer_pkg;

   localparam int unsigned VLEN    = 64;
   localparam int unsigned TsWidth = 32;

   localparam logic [3:0] PRIV_MASK_ALL = 4'hF;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_lvl_t;

   typedef struct packed {
      logic [VLEN-1:0]    pc;
      logic [31:0]        instr;
      logic               ex;
      logic               we;
      logic [4:0]         rd;
      logic [63:0]        wdata;
      priv_lvl_t          priv;
      logic               dbg;
      logic [TsWidth-1:0] ts;
      logic               lost;
   } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-port bundle from the core plus the valid/ready drain towards the sink.
interface commit_trace_buffer_if
   import commit_trace_buffer_pkg::*;
#(
   parameter int unsigned NrCommitPorts = 2
);
   logic [NrCommitPorts-1:0]            commit_valid;
   logic [NrCommitPorts-1:0][VLEN-1:0]  commit_pc;
   logic [NrCommitPorts-1:0][31:0]      commit_instr;
   logic [NrCommitPorts-1:0]            commit_ex;
   logic [NrCommitPorts-1:0]            commit_we;
   logic [NrCommitPorts-1:0][4:0]       commit_rd;
   logic [NrCommitPorts-1:0][63:0]      commit_wdata;

   logic                                trace_valid;
   logic                                trace_ready;
   trace_entry_t                        trace_entry;

   modport master (
      output commit_valid, commit_pc, commit_instr, commit_ex,
             commit_we, commit_rd, commit_wdata, trace_ready,
      input  trace_valid, trace_entry
   );

   modport slave (
      input  commit_valid, commit_pc, commit_instr, commit_ex,
             commit_we, commit_rd, commit_wdata, trace_ready,
      output trace_valid, trace_entry
   );
endinterface

// File: rtl/commit_trace_buffer_compact.sv
// Prefix count over the accepted ports: each accepted port gets its slot
// offset (ascending port order) and the total accepted count.
module commit_trace_buffer_compact #(
   parameter  int unsigned NrCommitPorts = 2,
   localparam int unsigned CntW          = $clog2(NrCommitPorts + 1)
) (
   input  logic [NrCommitPorts-1:0]           accept_i,
   output logic [NrCommitPorts-1:0][CntW-1:0] offset_o,
   output logic [CntW-1:0]                    count_o
);

   logic [CntW-1:0] run;

   always_comb begin
      run      = '0;
      offset_o = '0;
      for (int i = 0; i < NrCommitPorts; i++) begin
         offset_o[i] = run;
         run         = run + CntW'(accept_i[i]);
      end
      count_o = run;
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Filters retired instructions, timestamps them and stores them in a
// multi-write, single-read ring FIFO drained over valid/ready.
module commit_trace_buffer
   import commit_trace_buffer_pkg::*;
#(
   parameter  int unsigned NrCommitPorts = 2,
   parameter  int unsigned Depth         = 16,
   parameter  int unsigned DropCntW      = 16,
   localparam int unsigned PtrW          = $clog2(Depth),
   localparam int unsigned FillW         = PtrW + 1,
   localparam int unsigned CntW          = $clog2(NrCommitPorts + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic [3:0]                 priv_mask_i,
   input  logic                       trace_dbg_i,
   input  priv_lvl_t                  priv_lvl_i,
   input  logic                       debug_mode_i,
   input  logic                       clr_i,
   commit_trace_buffer_if.slave       bus_io,
   output logic [FillW-1:0]           fill_o,
   output logic [DropCntW-1:0]        drop_cnt_o,
   output logic                       overflow_o
);

   if ((Depth & (Depth - 1)) != 0) begin : g_depth_pow2
      $error("Depth must be a power of two");
   end
   if (Depth < NrCommitPorts) begin : g_depth_ports
      $error("Depth must be at least NrCommitPorts");
   end

   function automatic logic [DropCntW-1:0] sat_add(input logic [DropCntW-1:0] a,
                                                   input logic [CntW-1:0]     b);
      logic [DropCntW:0] sum;
      sum = {1'b0, a} + (DropCntW + 1)'(b);
      return sum[DropCntW] ? '1 : sum[DropCntW-1:0];
   endfunction

   trace_entry_t mem_q [Depth];

   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FillW-1:0]    fill_q, fill_d;
   logic [DropCntW-1:0] drop_q, drop_d;
   logic                ovf_q, ovf_d, lost_q, lost_d;
   logic [TsWidth-1:0]  ts_q, ts_d;

   logic [NrCommitPorts-1:0]           accept;
   logic [NrCommitPorts-1:0][CntW-1:0] offset;
   logic [CntW-1:0]                    acc_cnt;
   logic                               fits, do_write, do_drop, pop;

   logic [NrCommitPorts-1:0]           wr_en;
   logic [NrCommitPorts-1:0][PtrW-1:0] wr_idx;
   trace_entry_t                       wr_entry [NrCommitPorts];

   always_comb begin
      for (int i = 0; i < NrCommitPorts; i++) begin
         accept[i] = bus_io.commit_valid[i] & en_i & priv_mask_i[priv_lvl_i]
                     & (~debug_mode_i | trace_dbg_i);
      end
   end

   commit_trace_buffer_compact #(
      .NrCommitPorts (NrCommitPorts)
   ) u_compact (
      .accept_i (accept),
      .offset_o (offset),
      .count_o  (acc_cnt)
   );

   // Space is judged on the registered fill; a pop in the same cycle frees nothing.
   always_comb begin
      fits     = 32'(acc_cnt) <= 32'(FillW'(Depth) - fill_q);
      do_write = fits && (acc_cnt != '0);
      do_drop  = !fits;
      pop      = bus_io.trace_valid & bus_io.trace_ready;

      wr_ptr_d = do_write ? wr_ptr_q + PtrW'(acc_cnt) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      fill_d   = fill_q + (do_write ? FillW'(acc_cnt) : FillW'(0)) - FillW'(pop);
      ts_d     = ts_q + 1'b1;

      drop_d = drop_q;
      ovf_d  = ovf_q;
      lost_d = lost_q;
      if (do_drop) begin
         drop_d = sat_add(clr_i ? '0 : drop_q, acc_cnt);
         ovf_d  = 1'b1;
         lost_d = 1'b1;
      end else begin
         if (clr_i) begin
            drop_d = '0;
            ovf_d  = 1'b0;
            lost_d = 1'b0;
         end
         if (do_write) lost_d = 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < NrCommitPorts; i++) begin
         wr_en[i]          = accept[i] & fits;
         wr_idx[i]         = wr_ptr_q + PtrW'(offset[i]);
         wr_entry[i].pc    = bus_io.commit_pc[i];
         wr_entry[i].instr = bus_io.commit_instr[i];
         wr_entry[i].ex    = bus_io.commit_ex[i];
         wr_entry[i].we    = bus_io.commit_we[i];
         wr_entry[i].rd    = bus_io.commit_rd[i];
         wr_entry[i].wdata = bus_io.commit_wdata[i];
         wr_entry[i].priv  = priv_lvl_i;
         wr_entry[i].dbg   = debug_mode_i;
         wr_entry[i].ts    = ts_q;
         wr_entry[i].lost  = lost_q && (offset[i] == '0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         lost_q   <= 1'b0;
         ts_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         lost_q   <= lost_d;
         ts_q     <= ts_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NrCommitPorts; i++) begin
         if (wr_en[i]) mem_q[wr_idx[i]] <= wr_entry[i];
      end
   end

   assign bus_io.trace_valid = (fill_q != '0);
   assign bus_io.trace_entry = mem_q[rd_ptr_q];
   assign fill_o             = fill_q;
   assign drop_cnt_o         = drop_q;
   assign overflow_o         = ovf_q;

`ifndef SYNTHESIS
   assert property (@(posedge clk_i) disable iff (rst_i)
      (bus_io.trace_valid && !bus_io.trace_ready) |=> $stable(bus_io.trace_entry))
      else $error("trace_entry changed while stalled");
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed stimulus against a queue-based reference model;
// a separate monitor pops expected entries on every sink handshake.
module tb_commit_trace_buffer;
   import commit_trace_buffer_pkg::*;

   localparam int unsigned NP    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DCW   = 4;
   localparam int unsigned FILLW = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en, trace_dbg, debug_mode, clr;
   logic [3:0]       priv_mask;
   priv_lvl_t        priv_lvl;
   logic [FILLW-1:0] fill;
   logic [DCW-1:0]   drop_cnt;
   logic             overflow;

   commit_trace_buffer_if #(.NrCommitPorts(NP)) bus ();

   commit_trace_buffer #(
      .NrCommitPorts (NP),
      .Depth         (DEPTH),
      .DropCntW      (DCW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .priv_mask_i  (priv_mask),
      .trace_dbg_i  (trace_dbg),
      .priv_lvl_i   (priv_lvl),
      .debug_mode_i (debug_mode),
      .clr_i        (clr),
      .bus_io       (bus),
      .fill_o       (fill),
      .drop_cnt_o   (drop_cnt),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   trace_entry_t       sb_q[$];
   int                 m_fill, m_drop;
   bit                 m_ovf, m_lost;
   logic [TsWidth-1:0] m_ts;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_fill = 0; m_drop = 0; m_ovf = 0; m_lost = 0; m_ts = '0;
   endtask

   // Reference behaviour for one clock: accept, all-or-nothing store, drop accounting.
   task automatic model_step();
      int           acc[$];
      int           n;
      bit           pop, lost_in;
      trace_entry_t e;
      for (int i = 0; i < NP; i++)
         if (bus.commit_valid[i] && en && priv_mask[priv_lvl] && (!debug_mode || trace_dbg))
            acc.push_back(i);
      n       = acc.size();
      pop     = (m_fill > 0) && bus.trace_ready;
      lost_in = m_lost;
      if (n <= int'(DEPTH) - m_fill) begin
         if (clr) begin m_drop = 0; m_ovf = 0; m_lost = 0; end
         foreach (acc[k]) begin
            e.pc    = bus.commit_pc[acc[k]];
            e.instr = bus.commit_instr[acc[k]];
            e.ex    = bus.commit_ex[acc[k]];
            e.we    = bus.commit_we[acc[k]];
            e.rd    = bus.commit_rd[acc[k]];
            e.wdata = bus.commit_wdata[acc[k]];
            e.priv  = priv_lvl;
            e.dbg   = debug_mode;
            e.ts    = m_ts;
            e.lost  = lost_in && (k == 0);
            sb_q.push_back(e);
         end
         if (n > 0) m_lost = 0;
         m_fill = m_fill + n - int'(pop);
      end else begin
         m_drop = (clr ? 0 : m_drop) + n;
         if (m_drop > (1 << DCW) - 1) m_drop = (1 << DCW) - 1;
         m_ovf  = 1;
         m_lost = 1;
         m_fill = m_fill - int'(pop);
      end
      m_ts = m_ts + 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      chk("fill", fill, m_fill);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      chk("trace_valid", bus.trace_valid, m_fill != 0);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [NP-1:0] v, input bit rdy);
      bus.commit_valid = v;
      bus.trace_ready  = rdy;
      for (int i = 0; i < NP; i++) begin
         bus.commit_pc[i]    = {$urandom, $urandom & 32'hFFFF_FFFC};
         bus.commit_instr[i] = $urandom;
         bus.commit_ex[i]    = 1'($urandom);
         bus.commit_we[i]    = 1'($urandom);
         bus.commit_rd[i]    = 5'($urandom);
         bus.commit_wdata[i] = {$urandom, $urandom};
      end
   endtask

   task automatic drain();
      drive('0, 1'b1);
      for (int i = 0; i < 12 && m_fill > 0; i++) step();
      bus.trace_ready = 1'b0;
   endtask

   initial begin : monitor
      trace_entry_t exp;
      forever begin
         @(negedge clk);
         if (!rst && bus.trace_valid && bus.trace_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_entry", 1'b1, 1'b0);
            end else begin
               exp = sb_q.pop_front();
               chk("entry", bus.trace_entry, exp);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      en = 1'b1; priv_mask = PRIV_MASK_ALL; priv_lvl = PRIV_M;
      trace_dbg = 1'b0; debug_mode = 1'b0; clr = 1'b0;
      drive('0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Two ports in cycle 5, M-mode, full mask.
      repeat (5) step();
      drive(2'b11, 1'b0);
      bus.commit_pc[0] = 64'h8000_0000;
      bus.commit_pc[1] = 64'h8000_0004;
      step();
      chk("t1_fill", fill, 2);
      chk("t1_head_pc", bus.trace_entry.pc, 64'h8000_0000);
      chk("t1_head_ts", bus.trace_entry.ts, 5);
      chk("t1_head_lost", bus.trace_entry.lost, 0);
      drain();

      // Overflow: third pair dropped, lost marker on next stored entry only.
      repeat (3) begin drive(2'b11, 1'b0); step(); end
      chk("t2_fill", fill, DEPTH);
      chk("t2_drop", drop_cnt, 2);
      chk("t2_ovf", overflow, 1);
      drain();
      drive(2'b11, 1'b0); step();
      chk("t2_lost_first", bus.trace_entry.lost, 1);
      drain();

      // Privilege filter.
      drive('0, 1'b0); clr = 1'b1; step(); clr = 1'b0;
      priv_mask = 4'b1000; priv_lvl = PRIV_U;
      repeat (2) begin drive(2'b11, 1'b0); step(); end
      chk("t3_fill_u", fill, 0);
      chk("t3_drop_u", drop_cnt, 0);
      priv_lvl = PRIV_M;
      drive(2'b11, 1'b0); step();
      chk("t3_fill_m", fill, 2);
      drain();
      priv_mask = PRIV_MASK_ALL;

      // Debug-mode filter.
      debug_mode = 1'b1;
      drive(2'b11, 1'b0); step();
      chk("t4_fill_filtered", fill, 0);
      trace_dbg = 1'b1;
      drive(2'b01, 1'b0); step();
      chk("t4_fill_dbg", fill, 1);
      chk("t4_head_dbg", bus.trace_entry.dbg, 1);
      drain();
      debug_mode = 1'b0; trace_dbg = 1'b0;

      // Same-cycle pop frees no space.
      repeat (3) begin drive(2'b01, 1'b0); step(); end
      drive(2'b11, 1'b1); step();
      chk("t5_fill", fill, DEPTH - 2);
      chk("t5_drop", drop_cnt, 2);
      drain();

      // Saturation, clear-vs-drop priority, async reset.
      drive('0, 1'b0); clr = 1'b1; step(); clr = 1'b0;
      repeat (2) begin drive(2'b11, 1'b0); step(); end
      repeat (10) begin drive(2'b11, 1'b0); step(); end
      chk("t6_drop_sat", drop_cnt, 15);
      drive(2'b01, 1'b0); clr = 1'b1; step(); clr = 1'b0;
      chk("t6_clr_drop", drop_cnt, 1);
      chk("t6_clr_ovf", overflow, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", bus.trace_valid, 0);
      chk("t6_rst_fill", fill, 0);
      chk("t6_rst_drop", drop_cnt, 0);
      model_reset();
      drive('0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         drive(NP'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
         en         = ($urandom_range(0, 9) != 0);
         priv_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : PRIV_MASK_ALL;
         case ($urandom_range(0, 2))
            0:       priv_lvl = PRIV_U;
            1:       priv_lvl = PRIV_S;
            default: priv_lvl = PRIV_M;
         endcase
         debug_mode = ($urandom_range(0, 7) == 0);
         trace_dbg  = 1'($urandom);
         clr        = ($urandom_range(0, 15) == 0);
         step();
      end
      clr = 1'b0;
      drain();
      step();
      chk("final_fill", fill, 0);
      chk("final_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
